// File: rtl/count_pwm_stage.sv
// Purpose: samples the upcounter value, detects MAX->0 wraps, drives a double-buffered PWM and a period counter.
// Latency: pwm_out and wrap_pulse are registered, 1 clk after the q sample that causes them.
// Backpressure: none; q is consumed every cycle, duty writes are always accepted (latest write wins).
module count_pwm_stage #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  q,
    input  logic [N-1:0]  duty_in,
    input  logic          duty_wr,
    output logic          pwm_out,
    output logic          wrap_pulse,
    output logic          duty_pending,
    output logic [CW-1:0] cycle_count
);

    logic [N-1:0] q_d;
    logic         q_valid;
    logic [N-1:0] active_duty;
    logic [N-1:0] pending_duty;
    logic         wrap;

    // Wrap is only the MAX->0 step; q_valid masks the reset value of q_d.
    always_comb begin
        wrap = q_valid && (q_d == {N{1'b1}}) && (q == '0);
    end

    // Sample q, generate the wrap pulse, PWM output and period counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_d         <= '0;
            q_valid     <= 1'b0;
            wrap_pulse  <= 1'b0;
            pwm_out     <= 1'b0;
            cycle_count <= '0;
        end else begin
            q_d        <= q;
            q_valid    <= 1'b1;
            wrap_pulse <= wrap;
            // Compare uses the duty active before this edge; a transfer on
            // this edge shows up from the following edge.
            pwm_out    <= en && (q < active_duty);
            if (wrap && en && (cycle_count != {CW{1'b1}})) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

    // Duty double-buffer: writes land in pending, move to active only at a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_duty  <= '0;
            pending_duty <= '0;
            duty_pending <= 1'b0;
        end else begin
            if (wrap && duty_pending) begin
                active_duty <= pending_duty;
            end
            // A write coinciding with a wrap stays pending for the next wrap.
            if (duty_wr) begin
                pending_duty <= duty_in;
                duty_pending <= 1'b1;
            end else if (wrap) begin
                duty_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_pwm_stage.sv
module tb_count_pwm_stage;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] q;
    logic [3:0] duty_in;
    logic       duty_wr;
    logic       pwm_out;
    logic       wrap_pulse;
    logic       duty_pending;
    logic [7:0] cycle_count;

    count_pwm_stage #(.N(4), .CW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .q            (q),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .duty_pending (duty_pending),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] q;
        logic [3:0] din;
        logic       wr;
        logic       e_pwm;
        logic       e_wrap;
        logic       e_pend;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tv [22];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state for the free-running part
    logic [3:0] last_q;
    logic [3:0] prev_q;
    logic       m_valid;
    logic       m_wrap;
    logic [7:0] m_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock with q advancing like the upcounter; checks wrap and count every cycle.
    task automatic step();
        logic       a_rst;
        logic       a_en;
        a_rst  = rst_n;
        a_en   = en;
        last_q = q;
        @(posedge clk);
        #1;
        if (!a_rst) begin
            m_cnt   = 8'd0;
            m_valid = 1'b0;
            prev_q  = 4'd0;
            m_wrap  = 1'b0;
        end else begin
            m_wrap = m_valid && (prev_q == 4'd15) && (last_q == 4'd0);
            if (m_wrap && a_en && (m_cnt != 8'd255)) m_cnt = m_cnt + 8'd1;
            prev_q  = last_q;
            m_valid = 1'b1;
        end
        chk("step_wrap_pulse", int'(wrap_pulse), int'(m_wrap));
        chk("step_cycle_count", int'(cycle_count), int'(m_cnt));
        q       = q + 4'd1;
        duty_wr = 1'b0;
    endtask

    // Step until the edge that applied q=0 (the wrap edge), bounded.
    task automatic run_to_wrap(input string nm);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((last_q != 4'd0) && (k < 40));
        chk(nm, int'(last_q == 4'd0), 1);
    endtask

    // Check one full period after a transfer: per-cycle PWM and total high count.
    task automatic check_period(input string nm, input int duty);
        int highs;
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk(nm, int'(pwm_out), int'(en && (int'(last_q) < duty)));
            if (pwm_out) highs++;
        end
        chk({nm, "_highs"}, highs, en ? duty : 0);
    endtask

    initial begin
        int wraps;
        rst_n = 1'b0; en = 1'b0; q = 4'd0; duty_in = 4'd0; duty_wr = 1'b0;
        prev_q = 4'd0; m_valid = 1'b0; m_wrap = 1'b0; m_cnt = 8'd0; last_q = 4'd0;

        //            rst   en    q      din    wr  | pwm   wrap  pend  cnt
        tv[0]  = '{1'b0, 1'b1, 4'd3,  4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tv[1]  = '{1'b1, 1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tv[2]  = '{1'b1, 1'b1, 4'd0,  4'd6, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        tv[3]  = '{1'b1, 1'b1, 4'd1,  4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tv[4]  = '{1'b1, 1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tv[5]  = '{1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
        tv[6]  = '{1'b1, 1'b1, 4'd5,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        tv[7]  = '{1'b1, 1'b1, 4'd6,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        tv[8]  = '{1'b1, 1'b0, 4'd2,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        tv[9]  = '{1'b1, 1'b1, 4'd2,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        tv[10] = '{1'b1, 1'b0, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        tv[11] = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
        tv[12] = '{1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        tv[13] = '{1'b1, 1'b1, 4'd7,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        tv[14] = '{1'b1, 1'b1, 4'd15, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
        tv[15] = '{1'b1, 1'b1, 4'd0,  4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3};
        tv[16] = '{1'b1, 1'b1, 4'd1,  4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3};
        tv[17] = '{1'b1, 1'b1, 4'd2,  4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
        tv[18] = '{1'b1, 1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
        tv[19] = '{1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};
        tv[20] = '{1'b1, 1'b1, 4'd8,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
        tv[21] = '{1'b1, 1'b1, 4'd9,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};

        // Extra reset cycle so the DUT starts from a clean state
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            rst_n   = tv[i].rst_n;
            en      = tv[i].en;
            q       = tv[i].q;
            duty_in = tv[i].din;
            duty_wr = tv[i].wr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pwm", i),  int'(pwm_out),      int'(tv[i].e_pwm));
            chk($sformatf("vec%0d_wrap", i), int'(wrap_pulse),   int'(tv[i].e_wrap));
            chk($sformatf("vec%0d_pend", i), int'(duty_pending), int'(tv[i].e_pend));
            chk($sformatf("vec%0d_cnt", i),  int'(cycle_count),  int'(tv[i].e_cnt));
        end

        // Hand the running state over to the model (active duty is 9 now)
        duty_wr = 1'b0; en = 1'b1; rst_n = 1'b1;
        prev_q = 4'd9; m_valid = 1'b1; m_cnt = 8'd4;
        q = 4'd10;

        // Mid-period write of 5: pending until the wrap, then 5 high / 11 low
        duty_in = 4'd5; duty_wr = 1'b1;
        step();
        chk("d5_pending_after_write", int'(duty_pending), 1);
        while (q != 4'd0) begin
            step();
            chk("d5_pending_hold", int'(duty_pending), 1);
        end
        step();
        chk("d5_wrap_edge_pwm_old_duty", int'(pwm_out), 1);
        chk("d5_pending_cleared", int'(duty_pending), 0);
        check_period("d5_period", 5);

        // Duty 15: 15 high / 1 low
        duty_in = 4'd15; duty_wr = 1'b1;
        run_to_wrap("d15_reach_wrap");
        check_period("d15_period", 15);

        // en=0 for 40 clocks: PWM off, count frozen, wrap pulses continue
        en = 1'b0;
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("en0_pwm", int'(pwm_out), 0);
            if (wrap_pulse) wraps++;
        end
        chk("en0_wraps_seen", int'(wraps >= 2), 1);
        en = 1'b1;
        step();
        chk("en1_resume_pwm", int'(pwm_out), int'(last_q < 4'd15));

        // 300 periods: counter saturates at 255 and holds
        for (int i = 0; i < 300 * 16; i++) step();
        chk("sat_count", int'(cycle_count), 255);
        for (int i = 0; i < 32; i++) step();
        chk("sat_hold", int'(cycle_count), 255);

        // Reset mid-period with duty 5 active
        duty_in = 4'd5; duty_wr = 1'b1;
        run_to_wrap("rst_reach_wrap");
        while (q != 4'd6) step();
        rst_n = 1'b0;
        step();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_wrap", int'(wrap_pulse), 0);
        chk("rst_pend", int'(duty_pending), 0);
        chk("rst_cnt", int'(cycle_count), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_rst_pwm", int'(pwm_out), 0);
        end

        // Reset while q=15: the q=0 that follows is the first sample, not a wrap
        while (q != 4'd15) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("first_sample_no_wrap", int'(wrap_pulse), 0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("duty0_pwm", int'(pwm_out), 0);
        end
        duty_in = 4'd5; duty_wr = 1'b1;
        run_to_wrap("rearm_reach_wrap");
        check_period("rearm_d5_period", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
